// File: rtl/instruction_memory.sv
// Word-addressed instruction memory with a combinational fetch port and a byte-stream program loader.
// Optional XOR checksum of loaded words is built when IMEM_LOAD_CHECKSUM_EN is defined.
module instruction_memory #(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          pc,
    output logic [31:0]          instruction,
    input  logic                 load_start,
    input  logic [7:0]           load_data,
    input  logic                 load_valid,
    input  logic                 load_last,
    output logic                 load_ready,
    output logic                 load_busy,
    output logic                 processor_reset,
    output logic [ADDR_BITS:0]   load_word_count,
    output logic                 load_error
`ifdef IMEM_LOAD_CHECKSUM_EN
    ,
    output logic [31:0]          load_checksum
`endif
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [1:0]         byte_cnt_reg;
    logic [31:0]        word_reg;
    logic [ADDR_BITS:0] count_reg;
    logic               error_reg;

    logic [31:0]        mem [DEPTH];

    logic               accept;
    logic               word_done;
    logic               room;
    logic               write_en;
    logic               clear;
    logic [31:0]        word_next;
    logic               unused_pc_bits;

    assign unused_pc_bits = ^pc[1:0];

    // Fetch is purely combinational so the processor can register the word at its next edge.
    always_comb begin
        instruction = 32'h0;
        if (pc[31:ADDR_BITS+2] == '0)
            instruction = mem[pc[ADDR_BITS+1:2]];
    end

    assign accept    = (state_reg == LOAD) && load_valid;
    assign word_next = {word_reg[23:0], load_data};
    assign word_done = accept && (byte_cnt_reg == 2'd3);
    // count_reg doubles as the write address; its top bit means the array is full.
    assign room      = ~count_reg[ADDR_BITS];
    assign write_en  = word_done && room;
    assign clear     = (state_reg == IDLE) && load_start;

    // The array has no reset so a program survives a system reset.
    always_ff @(posedge clock) begin
        if (write_en)
            mem[count_reg[ADDR_BITS-1:0]] <= word_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            byte_cnt_reg <= 2'd0;
            word_reg     <= 32'h0;
            count_reg    <= '0;
            error_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (clear) begin
                byte_cnt_reg <= 2'd0;
                count_reg    <= '0;
                error_reg    <= 1'b0;
            end
            if (accept) begin
                word_reg     <= word_next;
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
                if (word_done) begin
                    if (room)
                        count_reg <= count_reg + 1'b1;
                    else
                        error_reg <= 1'b1;
                end
                if (load_last && (byte_cnt_reg != 2'd3))
                    error_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load_start) state_next = LOAD;
            LOAD:    if (accept && load_last) state_next = FLUSH;
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign load_ready      = (state_reg == LOAD);
    assign load_busy       = (state_reg != IDLE);
    assign processor_reset = reset | load_busy;
    assign load_word_count = count_reg;
    assign load_error      = error_reg;

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] checksum_reg;

    always_ff @(posedge clock) begin
        if (reset)
            checksum_reg <= 32'h0;
        else if (clear)
            checksum_reg <= 32'h0;
        else if (write_en)
            checksum_reg <= checksum_reg ^ word_next;
    end

    assign load_checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_instruction_memory.sv
// Directed self-checking bench for instruction_memory: a default-size instance and a 4-word instance for overflow.
module tb_instruction_memory;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc, s_pc;
    logic [31:0] instruction, s_instruction;
    logic        load_start, s_load_start;
    logic [7:0]  load_data, s_load_data;
    logic        load_valid, s_load_valid;
    logic        load_last, s_load_last;
    logic        load_ready, s_load_ready;
    logic        load_busy, s_load_busy;
    logic        processor_reset, s_processor_reset;
    logic [8:0]  load_word_count;
    logic [2:0]  s_load_word_count;
    logic        load_error, s_load_error;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] load_checksum, s_load_checksum;
`endif

    int tests = 0;
    int failures = 0;

    always #5 clock = ~clock;

    instruction_memory #(.ADDR_BITS(8)) dut (
        .clock(clock), .reset(reset), .pc(pc), .instruction(instruction),
        .load_start(load_start), .load_data(load_data), .load_valid(load_valid),
        .load_last(load_last), .load_ready(load_ready), .load_busy(load_busy),
        .processor_reset(processor_reset), .load_word_count(load_word_count),
        .load_error(load_error)
`ifdef IMEM_LOAD_CHECKSUM_EN
        , .load_checksum(load_checksum)
`endif
    );

    instruction_memory #(.ADDR_BITS(2)) dut_small (
        .clock(clock), .reset(reset), .pc(s_pc), .instruction(s_instruction),
        .load_start(s_load_start), .load_data(s_load_data), .load_valid(s_load_valid),
        .load_last(s_load_last), .load_ready(s_load_ready), .load_busy(s_load_busy),
        .processor_reset(s_processor_reset), .load_word_count(s_load_word_count),
        .load_error(s_load_error)
`ifdef IMEM_LOAD_CHECKSUM_EN
        , .load_checksum(s_load_checksum)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input bit sel);
        if (sel) s_load_start = 1'b1; else load_start = 1'b1;
        tick();
        load_start = 1'b0;
        s_load_start = 1'b0;
    endtask

    task automatic send(input bit sel, input logic [7:0] b, input logic last);
        if (sel) begin
            s_load_data = b; s_load_valid = 1'b1; s_load_last = last;
        end else begin
            load_data = b; load_valid = 1'b1; load_last = last;
        end
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        s_load_valid = 1'b0; s_load_last = 1'b0;
    endtask

    task automatic fetch(input bit sel, input logic [31:0] addr, input string tag, input logic [31:0] exp);
        if (sel) s_pc = addr; else pc = addr;
        #1;
        check(tag, sel ? s_instruction : instruction, exp);
    endtask

    initial begin
        logic [7:0] two_word [8];
        two_word = '{8'h24, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
        reset = 1'b1; pc = 32'h0; s_pc = 32'h0;
        load_start = 1'b0; load_data = 8'h0; load_valid = 1'b0; load_last = 1'b0;
        s_load_start = 1'b0; s_load_data = 8'h0; s_load_valid = 1'b0; s_load_last = 1'b0;

        // Reset
        tick();
        tick();
        check("rst_proc_reset_high", {31'h0, processor_reset}, 32'h1);
        reset = 1'b0;
        #1;
        check("rst_ready", {31'h0, load_ready}, 32'h0);
        check("rst_busy", {31'h0, load_busy}, 32'h0);
        check("rst_count", {23'h0, load_word_count}, 32'h0);
        check("rst_error", {31'h0, load_error}, 32'h0);
        check("rst_proc_reset_low", {31'h0, processor_reset}, 32'h0);
`ifdef IMEM_LOAD_CHECKSUM_EN
        check("rst_checksum", load_checksum, 32'h0);
`endif

        // Two-word load
        start(1'b0);
        check("start_ready", {31'h0, load_ready}, 32'h1);
        check("start_proc_reset", {31'h0, processor_reset}, 32'h1);
        for (int i = 0; i < 8; i++)
            send(1'b0, two_word[i], i == 7);
        check("flush_busy", {31'h0, load_busy}, 32'h1);
        check("flush_proc_reset", {31'h0, processor_reset}, 32'h1);
        check("flush_ready", {31'h0, load_ready}, 32'h0);
        tick();
        check("end_proc_reset", {31'h0, processor_reset}, 32'h0);
        check("end_busy", {31'h0, load_busy}, 32'h0);
        check("two_count", {23'h0, load_word_count}, 32'd2);
        check("two_error", {31'h0, load_error}, 32'h0);
        fetch(1'b0, 32'h0, "two_mem0", 32'h24010005);
        fetch(1'b0, 32'h4, "two_mem1", 32'h00000008);
`ifdef IMEM_LOAD_CHECKSUM_EN
        check("two_checksum", load_checksum, 32'h2401000D);
`endif

        // Partial final word
        start(1'b0);
        send(1'b0, 8'hAA, 1'b0);
        send(1'b0, 8'hBB, 1'b0);
        send(1'b0, 8'hCC, 1'b0);
        send(1'b0, 8'hDD, 1'b0);
        send(1'b0, 8'h11, 1'b0);
        send(1'b0, 8'h22, 1'b1);
        tick();
        check("part_count", {23'h0, load_word_count}, 32'd1);
        check("part_error", {31'h0, load_error}, 32'h1);
        check("part_idle", {31'h0, load_busy}, 32'h0);
        fetch(1'b0, 32'h0, "part_mem0", 32'hAABBCCDD);
        fetch(1'b0, 32'h4, "part_mem1_kept", 32'h00000008);
`ifdef IMEM_LOAD_CHECKSUM_EN
        check("part_checksum", load_checksum, 32'hAABBCCDD);
`endif

        // Reset mid-load after 5 bytes
        start(1'b0);
        for (int i = 1; i <= 5; i++)
            send(1'b0, 8'(i), 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("mid_busy", {31'h0, load_busy}, 32'h0);
        check("mid_ready", {31'h0, load_ready}, 32'h0);
        check("mid_count", {23'h0, load_word_count}, 32'h0);
        check("mid_error", {31'h0, load_error}, 32'h0);
        fetch(1'b0, 32'h0, "mid_mem0_kept", 32'h01020304);
`ifdef IMEM_LOAD_CHECKSUM_EN
        check("mid_checksum", load_checksum, 32'h0);
`endif
        start(1'b0);
        send(1'b0, 8'hCA, 1'b0);
        send(1'b0, 8'hFE, 1'b0);
        send(1'b0, 8'hBA, 1'b0);
        send(1'b0, 8'hBE, 1'b1);
        tick();
        check("reload_count", {23'h0, load_word_count}, 32'd1);
        check("reload_error", {31'h0, load_error}, 32'h0);
        fetch(1'b0, 32'h0, "reload_mem0", 32'hCAFEBABE);

        // Fetch range
        fetch(1'b0, 32'h00010000, "fetch_out_of_range", 32'h0);
        fetch(1'b0, 32'h00000003, "fetch_low_bits", 32'hCAFEBABE);

        // Stalled stream with a write/read collision on the final byte
        start(1'b0);
        send(1'b0, 8'h12, 1'b0);
        repeat (3) tick();
        send(1'b0, 8'h34, 1'b0);
        repeat (3) tick();
        send(1'b0, 8'h56, 1'b0);
        repeat (3) tick();
        pc = 32'h0;
        load_data = 8'h78; load_valid = 1'b1; load_last = 1'b1;
        #1;
        check("collide_old_word", instruction, 32'hCAFEBABE);
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        #1;
        check("collide_new_word", instruction, 32'h12345678);
        tick();
        check("stall_count", {23'h0, load_word_count}, 32'd1);

        // Overflow on the 4-word instance
        start(1'b1);
        for (int w = 1; w <= 5; w++)
            for (int b = 0; b < 4; b++)
                send(1'b1, 8'(w), (w == 5) && (b == 3));
        check("ovf_flush", {31'h0, s_load_busy}, 32'h1);
        tick();
        check("ovf_idle", {31'h0, s_load_busy}, 32'h0);
        check("ovf_count", {29'h0, s_load_word_count}, 32'd4);
        check("ovf_error", {31'h0, s_load_error}, 32'h1);
        fetch(1'b1, 32'h0, "ovf_mem0", 32'h01010101);
        fetch(1'b1, 32'h4, "ovf_mem1", 32'h02020202);
        fetch(1'b1, 32'h8, "ovf_mem2", 32'h03030303);
        fetch(1'b1, 32'hC, "ovf_mem3", 32'h04040404);
        fetch(1'b1, 32'h10, "ovf_out_of_range", 32'h0);
`ifdef IMEM_LOAD_CHECKSUM_EN
        check("ovf_checksum", s_load_checksum, 32'h04040404);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
